// File: rtl/wb_interconnect.sv
`default_nettype none
// ============================================================================
//  Module   : wb_interconnect
//  Purpose  : Single-master Wishbone address decoder with per-transfer ack
//             timeout, error capture and saturating timeout counter.
//  Revision : 1.0
// ============================================================================
module wb_interconnect #(
    parameter int          SEL_WIDTH  = 4,
    parameter int          DATA_WIDTH = 32,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset_n,
    input  logic                                   i_wb_cyc,
    input  logic                                   i_wb_stb,
    input  logic [31:0]                            i_wb_addr,
    output logic [DATA_WIDTH-1:0]                  o_wb_dat,
    output logic                                   o_wb_ack,
    output logic                                   o_wb_err,
    output logic [(2**SEL_WIDTH)-1:0]              o_slave_sel,
    input  logic [(2**SEL_WIDTH)*DATA_WIDTH-1:0]   i_slave_dat,
    input  logic [(2**SEL_WIDTH)-1:0]              i_slave_ack,
    output logic [31:0]                            o_err_addr,
    output logic [7:0]                             o_err_count
);

    localparam int                    NSLV        = 2**SEL_WIDTH;
    localparam logic [15:0]           TIMEOUT_CNT = 16'(TIMEOUT);
    localparam logic [DATA_WIDTH-1:0] ERR_WORD    = DATA_WIDTH'(ERR_DATA);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]            state;
    logic [SEL_WIDTH-1:0]  slave_idx;
    logic [31:0]           addr_q;
    logic [15:0]           wait_cnt;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_ack;
    logic                  timeout_hit;
    logic [SEL_WIDTH-1:0]  req_idx;
    logic [NSLV-1:0]       req_onehot;

    assign req_idx     = i_wb_addr[31 -: SEL_WIDTH];
    assign req_onehot  = NSLV'(1) << req_idx;
    assign sel_ack     = i_slave_ack[slave_idx];
    assign timeout_hit = (wait_cnt == TIMEOUT_CNT);

    // Read-data mux: only the latched slave's slice can reach the master.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (SEL_WIDTH'(k) == slave_idx) begin
                sel_data = i_slave_dat[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            slave_idx   <= '0;
            addr_q      <= '0;
            wait_cnt    <= '0;
            o_slave_sel <= '0;
            o_wb_ack    <= 1'b0;
            o_wb_err    <= 1'b0;
            o_wb_dat    <= '0;
            o_err_addr  <= '0;
            o_err_count <= '0;
        end else begin
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_wb_cyc && i_wb_stb) begin
                        slave_idx   <= req_idx;
                        addr_q      <= i_wb_addr;
                        wait_cnt    <= '0;
                        o_slave_sel <= req_onehot;
                        state       <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // Master abort outranks any completion seen in the same cycle.
                    if (!i_wb_cyc) begin
                        o_slave_sel <= '0;
                        state       <= IDLE;
                    end else if (sel_ack) begin
                        o_wb_dat    <= sel_data;
                        o_wb_ack    <= 1'b1;
                        o_slave_sel <= '0;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        o_wb_dat    <= ERR_WORD;
                        o_wb_err    <= 1'b1;
                        o_err_addr  <= addr_q;
                        if (o_err_count != 8'hFF) begin
                            o_err_count <= o_err_count + 8'd1;
                        end
                        o_slave_sel <= '0;
                        state       <= RESP;
                    end else if (wait_cnt != 16'hFFFF) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    o_slave_sel <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/wb_interconnect.md
WB_INTERCONNECT -- requirements
Module: wb_interconnect

Interface
REQ-001 Parameter SEL_WIDTH, default 4: number of top address bits used for slave decode; NSLV = 2**SEL_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 32: width of read data per slave.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles a selected slave may take to ack (range 1..65535).
REQ-004 Parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on timeout (truncated to DATA_WIDTH).
REQ-005 i_clk  in  1  single clock; all logic on rising edge.
REQ-006 i_reset_n  in  1  asynchronous active-low reset.
REQ-007 i_wb_cyc  in  1  master bus cycle.
REQ-008 i_wb_stb  in  1  master strobe.
REQ-009 i_wb_addr  in  32  master address; bits [31:32-SEL_WIDTH] select the slave.
REQ-010 o_wb_dat  out  DATA_WIDTH  registered read data to master.
REQ-011 o_wb_ack  out  1  one-cycle completion pulse, normal.
REQ-012 o_wb_err  out  1  one-cycle completion pulse, timeout.
REQ-013 o_slave_sel  out  NSLV  registered one-hot slave select.
REQ-014 i_slave_dat  in  NSLV*DATA_WIDTH  packed slave read data, slave k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-015 i_slave_ack  in  NSLV  per-slave ack.
REQ-016 o_err_addr  out  32  address of the most recent timed-out transfer.
REQ-017 o_err_count  out  8  saturating count of timeouts.

Function
REQ-018 FSM states IDLE, ACTIVE, RESP; one outstanding transfer only.
REQ-019 IDLE: on i_wb_cyc & i_wb_stb, latch index and address, clear wait counter, go ACTIVE; o_slave_sel bit[index] high from next cycle.
REQ-020 ACTIVE: o_slave_sel one-hot held; wait counter increments by 1 each cycle, 16-bit, never wraps.
REQ-021 ACTIVE with i_slave_ack[index]=1: register i_slave_dat slice of index into o_wb_dat, go RESP with o_wb_ack=1 next cycle.
REQ-022 Acks from non-selected slaves SHALL be ignored.
REQ-023 ACTIVE with wait counter == TIMEOUT and no ack that cycle: o_wb_dat=ERR_DATA, o_wb_err=1 next cycle, o_err_addr=latched address, o_err_count+1 saturating at 255, go RESP.
REQ-024 Ack and timeout in same cycle: ack wins, no error recorded.
REQ-025 ACTIVE with i_wb_cyc=0: abort, o_slave_sel cleared next cycle, no ack/err, return IDLE.
REQ-026 RESP: exactly one cycle; o_slave_sel all zero; o_wb_ack or o_wb_err high (never both); then IDLE.
REQ-027 o_wb_dat SHALL hold its value until the next completion.
REQ-028 Minimum latency: request sampled cycle 0, sel high cycle 1, slave acks cycle 1, o_wb_ack high cycle 2; back-to-back request accepted cycle 3.
REQ-029 A request held asserted in RESP SHALL be treated as a new request only once back in IDLE.

Reset
REQ-030 On i_reset_n low, asynchronously: state IDLE, o_slave_sel=0, o_wb_ack=0, o_wb_err=0, o_wb_dat=0, o_err_addr=0, o_err_count=0, wait counter 0.
REQ-031 Reset mid-transfer SHALL drop the transfer with no ack/err after release.
REQ-032 First request SHALL be accepted the cycle after i_reset_n rises.

Verification
REQ-033 Addr 0x1000_0010, slave 1 acks on first sel cycle with 0x1234_5678 -> o_slave_sel=0x0002 cycle 1, o_wb_ack cycle 2, o_wb_dat=0x1234_5678.
REQ-034 Addr 0x3000_0000, slave 3 never acks, TIMEOUT=4 -> o_wb_err one pulse, o_wb_dat=0xDEAD_BEEF, o_err_addr=0x3000_0000, o_err_count=1.
REQ-035 Slave 2 acks while slave 0 selected -> ignored; slave 0 ack 3 cycles later -> o_wb_ack with slave 0 data.
REQ-036 Slave ack on the exact TIMEOUT cycle -> o_wb_ack=1, o_wb_err=0, o_err_count unchanged.
REQ-037 i_wb_cyc dropped in ACTIVE, then i_reset_n pulsed mid next transfer -> no ack/err, all outputs 0, next request completes normally.
REQ-038 300 consecutive timeouts -> o_err_count=255, no wrap.
